// File: rtl/multicycle_subtractor_if.sv
// rtl/multicycle_subtractor_if.sv - operand/result handshake bundle for multicycle_subtractor
//
// Purpose : groups the operand handshake (in_valid/in_ready, a, b, bin) and the
//           result handshake (out_valid/out_ready, diff, bout, zero, ovf).
// Modports: master - operand source / result consumer side
//           slave  - the subtractor itself
interface multicycle_subtractor_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             zero;
  logic             ovf;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, zero, ovf
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, zero, ovf
  );
endinterface

// File: rtl/multicycle_subtractor.sv
// rtl/multicycle_subtractor.sv - multi-cycle a - b - bin, DIGIT bits per clock
//
// Purpose : computes diff = a - b - bin over N = WIDTH/DIGIT BUSY cycles with a
//           ripple borrow carried between cycles; flags bout/zero/ovf.
// Ports   : clk   - rising-edge clock
//           rst_n - asynchronous active-low reset
//           bus   - multicycle_subtractor_if.slave (operand and result handshakes)
// Option  : MULTICYCLE_SUBTRACTOR_SAT_EN - saturate diff on two's-complement overflow
module multicycle_subtractor #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  multicycle_subtractor_if.slave  bus
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (((WIDTH % DIGIT) != 0) || (WIDTH < 2)) begin : g_bad_cfg
    $error("multicycle_subtractor: DIGIT must divide WIDTH and WIDTH must be >= 2");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res;
  logic             r_borrow;
  logic             r_sa;
  logic             r_sb;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_zero;
  logic             r_ovf;

  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_accept;
  logic             w_last;
  logic [DIGIT:0]   w_dig_sub;
  logic [DIGIT-1:0] w_dig;
  logic             w_borrow_next;
  logic [WIDTH-1:0] w_res_next;
  logic [WIDTH-1:0] w_final;
  logic             w_ovf;

  assign w_accept = w_in_ready && bus.in_valid;
  assign w_last   = (r_count == LAST);

  // One digit of DIGIT chained full-subtractor cells; the extra MSB of the
  // widened difference is the borrow out of the digit.
  assign w_dig_sub     = {1'b0, r_a_sh[DIGIT-1:0]} - {1'b0, r_b_sh[DIGIT-1:0]}
                       - {{DIGIT{1'b0}}, r_borrow};
  assign w_dig         = w_dig_sub[DIGIT-1:0];
  assign w_borrow_next = w_dig_sub[DIGIT];

  // Digits are produced LSB first, so they enter the result from the MSB side;
  // after N shifts the first digit has reached bit 0.
  if (DIGIT == WIDTH) begin : g_single
    assign w_res_next = w_dig;
  end else begin : g_shift
    assign w_res_next = {w_dig, r_res[WIDTH-1:DIGIT]};
  end

  assign w_ovf = (r_sa != r_sb) && (w_res_next[WIDTH-1] != r_sa);

`ifdef MULTICYCLE_SUBTRACTOR_SAT_EN
  assign w_final = w_ovf ? (r_sa ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}})
                         : w_res_next;
`else
  assign w_final = w_res_next;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.in_valid) w_state_next = S_BUSY;
      S_BUSY:  if (w_last) w_state_next = S_DONE;
      S_DONE:  if (bus.out_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // FSM outputs, decoded from the state register only
  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      S_IDLE:  w_in_ready  = 1'b1;
      S_DONE:  w_out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= '0;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_res    <= '0;
      r_borrow <= 1'b0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_count  <= '0;
      r_a_sh   <= bus.a;
      r_b_sh   <= bus.b;
      r_res    <= '0;
      r_borrow <= bus.bin;
      r_sa     <= bus.a[WIDTH-1];
      r_sb     <= bus.b[WIDTH-1];
    end else if (r_state == S_BUSY) begin
      r_count  <= r_count + 1'b1;
      r_a_sh   <= r_a_sh >> DIGIT;
      r_b_sh   <= r_b_sh >> DIGIT;
      r_res    <= w_res_next;
      r_borrow <= w_borrow_next;
      if (w_last) begin
        r_diff <= w_final;
        r_bout <= w_borrow_next;
        r_zero <= (w_final == '0);
        r_ovf  <= w_ovf;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.diff      = r_diff;
  assign bus.bout      = r_bout;
  assign bus.zero      = r_zero;
  assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_multicycle_subtractor.sv
// tb/tb_multicycle_subtractor.sv - scoreboard bench for multicycle_subtractor
module tb_multicycle_subtractor;
  localparam int WIDTH = 16;
  localparam int DIGIT = 4;
  localparam int N     = WIDTH / DIGIT;

  typedef struct {
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             zero;
    logic             ovf;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  exp_t q[$];
  exp_t m_exp;

  multicycle_subtractor_if #(.WIDTH(WIDTH)) vif ();

  multicycle_subtractor #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (vif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a result is consumed whenever out_valid && out_ready.
  always @(negedge clk) begin
    if (rst_n && vif.out_valid && vif.out_ready) begin
      if (q.size() == 0) begin
        check("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        m_exp = q.pop_front();
        check("diff", {16'd0, vif.diff}, {16'd0, m_exp.diff});
        check("bout", {31'd0, vif.bout}, {31'd0, m_exp.bout});
        check("zero", {31'd0, vif.zero}, {31'd0, m_exp.zero});
        check("ovf",  {31'd0, vif.ovf},  {31'd0, m_exp.ovf});
      end
    end
  end

  task automatic push_exp(input logic [WIDTH-1:0] ed, input logic eb, input logic ez,
                          input logic eo);
    exp_t t;
    t.diff = ed;
    t.bout = eb;
    t.zero = ez;
    t.ovf  = eo;
    q.push_back(t);
  endtask

  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin,
                      input logic [WIDTH-1:0] ed, input logic eb, input logic ez,
                      input logic eo, input bit lat);
    bit acc;
    acc = 1'b0;
    @(posedge clk);
    #1;
    vif.in_valid = 1'b1;
    vif.a        = a;
    vif.b        = b;
    vif.bin      = bin;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      if (vif.in_ready) begin
        @(posedge clk);
        acc = 1'b1;
        push_exp(ed, eb, ez, eo);
        #1;
        vif.in_valid = 1'b0;
        vif.a        = 16'hDEAD;
        vif.b        = 16'hBEEF;
        vif.bin      = 1'b1;
      end
    end
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
    if (lat && acc) begin
      for (int i = 0; i <= N; i++) begin
        @(negedge clk);
        check("latency_out_valid", {31'd0, vif.out_valid}, (i == N) ? 32'd1 : 32'd0);
      end
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (q.size() == 0) done = 1'b1;
    end
    if (!done) check("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    bit seen;
    n_vec         = 0;
    n_err         = 0;
    rst_n         = 1'b0;
    vif.in_valid  = 1'b0;
    vif.a         = '0;
    vif.b         = '0;
    vif.bin       = 1'b0;
    vif.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  {31'd0, vif.in_ready},  32'd1);
    check("rst_out_valid", {31'd0, vif.out_valid}, 32'd0);
    check("rst_diff",      {16'd0, vif.diff},      32'd0);
    check("rst_flags",     {29'd0, vif.bout, vif.zero, vif.ovf}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // a, b, bin, expected diff, bout, zero, ovf
    send(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b1);
    send(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef MULTICYCLE_SUBTRACTOR_SAT_EN
    send(16'h8000, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b0);
    send(16'h7FFF, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b0, 1'b1, 1'b0);
`else
    send(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b1, 1'b0);
    send(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b0);
`endif
    send(16'h0005, 16'h0004, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    send(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0);
    send(16'hA5A5, 16'h5A5A, 1'b0, 16'h4B4B, 1'b0, 1'b0, 1'b1, 1'b0);
    drain();

    // Backpressure: result held while new operands are offered.
    vif.out_ready = 1'b0;
    send(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (vif.out_valid) seen = 1'b1;
    end
    if (!seen) check("bp_out_valid_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    vif.in_valid = 1'b1;
    vif.a        = 16'h0010;
    vif.b        = 16'h0001;
    vif.bin      = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", {31'd0, vif.out_valid}, 32'd1);
      check("bp_in_ready",  {31'd0, vif.in_ready},  32'd0);
      check("bp_diff",      {16'd0, vif.diff},      32'h1000);
      check("bp_flags",     {29'd0, vif.bout, vif.zero, vif.ovf}, 32'd0);
    end
    @(posedge clk);
    #1 vif.out_ready = 1'b1;
    @(negedge clk);
    check("bp_in_ready_at_hs", {31'd0, vif.in_ready}, 32'd0);
    @(posedge clk);
    push_exp(16'h000F, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("bp_in_ready_after_hs",  {31'd0, vif.in_ready},  32'd1);
    check("bp_out_valid_after_hs", {31'd0, vif.out_valid}, 32'd0);
    @(posedge clk);
    #1;
    vif.in_valid = 1'b0;
    @(negedge clk);
    check("bp_pending_taken", {31'd0, vif.in_ready}, 32'd0);
    drain();

    // Reset two cycles into BUSY aborts the operation.
    @(posedge clk);
    #1;
    vif.in_valid = 1'b1;
    vif.a        = 16'h1234;
    vif.b        = 16'h0234;
    vif.bin      = 1'b0;
    @(negedge clk);
    check("rst_mid_pre_in_ready", {31'd0, vif.in_ready}, 32'd1);
    @(posedge clk);
    #1 vif.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_diff",      {16'd0, vif.diff},      32'd0);
    check("rst_mid_out_valid", {31'd0, vif.out_valid}, 32'd0);
    check("rst_mid_in_ready",  {31'd0, vif.in_ready},  32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < N + 3; i++) begin
      @(negedge clk);
      check("rst_mid_no_out_valid", {31'd0, vif.out_valid}, 32'd0);
    end
    send(16'h00FF, 16'h000F, 1'b0, 16'h00F0, 1'b0, 1'b0, 1'b0, 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
